// File: rtl/ahb_defs.sv
// Shared AHB-Lite encodings and SRAM-slave FSM states.
// Reused by spi_loader and the core bus interface.
package ahb_defs;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RSTALL,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Little-endian byte-lane strobes for a legal access.
  function automatic logic [3:0] lane_strobe(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      HSIZE_BYTE: lane_strobe = 4'b0001 << lo;
      HSIZE_HALF: lane_strobe = lo[1] ? 4'b1100 : 4'b0011;
      default:    lane_strobe = 4'b1111;
    endcase
  endfunction

  function automatic logic access_illegal(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      HSIZE_BYTE: access_illegal = 1'b0;
      HSIZE_HALF: access_illegal = lo[0];
      HSIZE_WORD: access_illegal = (lo != 2'b00);
      default:    access_illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/sram_sp.sv
// Single-port synchronous RAM, 32-bit words, byte enables, 1-cycle read latency.
// Kept standalone so a foundry macro can drop in.
module sram_sp #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1 << ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave fronting the program/data RAM: zero-wait reads/writes,
// one stall on read-after-write, two-cycle ERROR for illegal accesses.
module ahb_sram_slave
  import ahb_defs::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  state_e                state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            size_q;
  logic [1:0]            lo_q;

  logic                  ram_en, ram_we;
  logic [3:0]            ram_be;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_rdata;

  logic ready_state, take, illegal, rd_issue;
  logic unused_bits;

  assign unused_bits = ^{hburst, haddr[31:ADDR_WIDTH+2], htrans[0]};

  assign ready_state = (state == ST_IDLE) || (state == ST_WRITE) ||
                       (state == ST_READ) || (state == ST_ERR2);
  assign take        = hsel & htrans[1] & hready & ready_state;
  assign illegal     = access_illegal(hsize, haddr[1:0]);
  // The RAM port is busy committing the write in WRITE, so that read is deferred to RSTALL.
  assign rd_issue    = take & ~illegal & ~hwrite & (state != ST_WRITE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      size_q <= '0;
      lo_q   <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        addr_q <= haddr[ADDR_WIDTH+1:2];
        size_q <= hsize;
        lo_q   <= haddr[1:0];
      end
    end
  end

  always_comb begin
    state_nx  = ST_IDLE;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = '0;
    ram_addr  = addr_q;

    if (take) begin
      if (illegal)                state_nx = ST_ERR1;
      else if (hwrite)            state_nx = ST_WRITE;
      else if (state == ST_WRITE) state_nx = ST_RSTALL;
      else                        state_nx = ST_READ;
    end

    if (rd_issue) begin
      ram_en   = 1'b1;
      ram_addr = haddr[ADDR_WIDTH+1:2];
    end

    case (state)
      ST_WRITE: begin
        ram_en = 1'b1;
        ram_we = 1'b1;
        ram_be = lane_strobe(size_q, lo_q);
      end
      ST_RSTALL: begin
        hreadyout = 1'b0;
        ram_en    = 1'b1;
        state_nx  = ST_READ;
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_nx  = ST_ERR2;
      end
      ST_ERR2: hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  assign hrdata = (state == ST_READ) ? ram_rdata : '0;

  sram_sp #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (hwdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed self-checking bench for ahb_sram_slave.
module tb_ahb_sram_slave;
  import ahb_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic        hready_blk;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  int n_tests = 0;
  int n_fail  = 0;

  assign hready = hreadyout & ~hready_blk;

  always #5 clk = ~clk;

  ahb_sram_slave #(.ADDR_WIDTH(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hburst    (hburst),
    .hwdata    (hwdata),
    .hready    (hready),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hrdata    (hrdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    hsel   = sel;
    htrans = trans;
    hwrite = wr;
    hsize  = size;
    haddr  = addr;
    hwdata = wdata;
  endtask

  task automatic idle(input logic [31:0] wdata);
    drive(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, wdata);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bus(input string tag, input logic rdy, input logic rsp, input logic [31:0] rd);
    check({tag, ".rdy"}, {31'b0, hreadyout}, {31'b0, rdy});
    check({tag, ".rsp"}, {31'b0, hresp}, {31'b0, rsp});
    check({tag, ".rd"}, hrdata, rd);
  endtask

  function automatic logic [31:0] burst_word(input int i);
    return 32'hB000_0000 + i * 32'h0001_0203;
  endfunction

  initial begin
    reset = 1'b0;
    hready_blk = 1'b0;
    hburst = 3'd0;
    idle(32'h0);
    repeat (3) tick();
    check_bus("reset", 1'b1, 1'b0, 32'h0);
    reset = 1'b1;
    tick();

    // Word write then read of the same word: one RSTALL cycle.
    drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'h0);
    tick();
    check_bus("w10.data", 1'b1, 1'b0, 32'h0);
    drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'hDEADBEEF);
    tick();
    check_bus("r10.stall", 1'b0, 1'b0, 32'h0);
    tick();
    check_bus("r10.data", 1'b1, 1'b0, 32'hDEADBEEF);
    idle(32'h0);
    tick();
    check_bus("r10.idle", 1'b1, 1'b0, 32'h0);

    // Blocked hready in IDLE: read must not be captured.
    hready_blk = 1'b1;
    drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
    tick();
    hready_blk = 1'b0;
    idle(32'h0);
    check_bus("blocked", 1'b1, 1'b0, 32'h0);
    tick();

    // Byte writes 0x20..0x23 with junk in unselected lanes, then two reads.
    drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h20, 32'h0);
    tick();
    drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h21, 32'hEEEEEE11);
    tick();
    check("b21.rdy", {31'b0, hreadyout}, 32'h1);
    drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h22, 32'hEEEE22EE);
    tick();
    drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h23, 32'hEE33EEEE);
    tick();
    check("b23.rdy", {31'b0, hreadyout}, 32'h1);
    drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'h44EEEEEE);
    tick();
    check_bus("r20a.stall", 1'b0, 1'b0, 32'h0);
    tick();
    check_bus("r20a.data", 1'b1, 1'b0, 32'h44332211);
    drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'h0);
    tick();
    check_bus("r20b.data", 1'b1, 1'b0, 32'h44332211);
    idle(32'h0);
    tick();

    // Halfword to upper lanes over a zeroed word.
    drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h30, 32'h0);
    tick();
    drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h32, 32'h0);
    tick();
    drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h30, 32'hABCD1234);
    tick();
    tick();
    check_bus("r30.data", 1'b1, 1'b0, 32'hABCD0000);
    idle(32'h0);
    tick();

    // Misaligned word write: ERR1 then ERR2, RAM untouched.
    drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h40, 32'h0);
    tick();
    idle(32'h12345678);
    tick();
    drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h41, 32'h0);
    tick();
    check_bus("err41.e1", 1'b0, 1'b1, 32'h0);
    idle(32'hFFFFFFFF);
    tick();
    check_bus("err41.e2", 1'b1, 1'b1, 32'h0);
    drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h40, 32'h0);
    tick();
    check_bus("r40.data", 1'b1, 1'b0, 32'h12345678);

    // hsize=3 is illegal even when aligned.
    drive(1'b1, HTRANS_NONSEQ, 1'b1, 3'd3, 32'h40, 32'h0);
    tick();
    check_bus("errsz.e1", 1'b0, 1'b1, 32'h0);
    idle(32'hFFFFFFFF);
    tick();
    check_bus("errsz.e2", 1'b1, 1'b1, 32'h0);
    drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h40, 32'h0);
    tick();
    check("r40b.data", hrdata, 32'h12345678);
    idle(32'h0);
    tick();

    // 16-beat INCR write burst, then back-to-back readback.
    hburst = 3'd1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1, HSIZE_WORD,
            32'(4 * i), (i == 0) ? 32'h0 : burst_word(i - 1));
      tick();
      check($sformatf("burst.w%0d.rdy", i), {31'b0, hreadyout}, 32'h1);
    end
    idle(burst_word(15));
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'(4 * i), 32'h0);
      tick();
      check($sformatf("burst.r%0d", i), hrdata, burst_word(i));
      check($sformatf("burst.r%0d.rdy", i), {31'b0, hreadyout}, 32'h1);
    end
    hburst = 3'd0;
    idle(32'h0);
    tick();

    // Reset during a write data phase drops the write.
    drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h50, 32'h0);
    tick();
    idle(32'h0BADF00D);
    tick();
    drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h50, 32'h0);
    tick();
    idle(32'hFFFFFFFF);
    #2 reset = 1'b0;
    #1;
    check_bus("rst.mid", 1'b1, 1'b0, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h50, 32'h0);
    tick();
    check_bus("r50.data", 1'b1, 1'b0, 32'h0BADF00D);
    idle(32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite slave that terminates the `spi_h*` bus driven by `spi_loader` and fronts the on-chip program/data RAM. While `core_rst` holds the RISC-V core in reset, the loader writes the boot image through this block. Afterwards the same port serves core fetches and loads. It provides zero-wait-state reads and writes, one wait state on a read that follows a write, and a two-cycle ERROR response for illegal accesses.

## Interface
Parameters:
- `ADDR_WIDTH`, 10, word-address bits; RAM depth is 2^ADDR_WIDTH 32-bit words (4 KiB default).

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `hsel` in 1: slave select from the address decoder.
- `haddr` in 32: byte address. Bits [ADDR_WIDTH+1:2] index the RAM; upper bits are ignored, so the RAM aliases.
- `htrans` in 2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `hwrite` in 1: 1 = write.
- `hsize` in 3: 0 = byte, 1 = halfword, 2 = word; values ≥3 are illegal.
- `hburst` in 3: accepted and ignored; each beat is handled independently.
- `hwdata` in 32: write data, valid in the data phase.
- `hready` in 1: bus-level HREADY; an address phase is sampled only when this is 1.
- `hreadyout` out 1: slave ready.
- `hresp` out 1: 0 = OKAY, 1 = ERROR.
- `hrdata` out 32: read data.

## Operation
- Address phase accepted when `hsel & htrans[1] & hready`. On acceptance, register the word address, `hwrite`, `hsize`, `haddr[1:0]`.
- Illegal access: `hsize`≥3, or misaligned (halfword with `haddr[0]`=1, word with `haddr[1:0]`≠0). An illegal access does not touch the RAM.
- Byte lanes are little-endian:
  - Byte: lane = `haddr[1:0]`.
  - Halfword: lanes {1,0} if `haddr[1]`=0, else {3,2}.
  - Word: all four lanes.
- FSM states: IDLE, WRITE, READ, RSTALL, ERR1, ERR2.
- IDLE: `hreadyout`=1, `hresp`=0. Transitions on an accepted transfer:
  - Illegal → ERR1.
  - Legal write → WRITE.
  - Legal read → READ. The RAM read is issued this cycle using the combinational `haddr`.
- WRITE (data phase): `hreadyout`=1. The RAM write of `hwdata` with the lane strobes commits at the closing edge. The next state follows the accepted-transfer rules, except a legal read goes to RSTALL, because the single RAM port is busy with the write.
- RSTALL: `hreadyout`=0, `hresp`=0. The RAM read is issued from the registered address. Next state is READ.
- READ: `hreadyout`=1. `hrdata` is the full 32-bit RAM word (the master selects lanes). The next state follows the accepted-transfer rules; read-after-read needs no stall.
- ERR1: `hreadyout`=0, `hresp`=1. Next state is ERR2.
- ERR2: `hreadyout`=1, `hresp`=1. Any address phase presented here is evaluated as in IDLE.
- No accepted transfer (IDLE/BUSY, `hsel`=0, or `hready`=0) in any ready state → IDLE.
- `hrdata` is 0 in all states except READ.

## Timing
- Reset values: `hreadyout`=1, `hresp`=0, `hrdata`=0, FSM in IDLE.
- Reset asserted mid-transfer drops any pending write and returns to IDLE. RAM contents are not cleared.
- Latency from address phase to completed data phase:
  - Write: 1 cycle.
  - Read after IDLE/READ/ERR2: 1 cycle.
  - Read after WRITE: 2 cycles.
  - Error: 2 cycles.
- A read of the word just written, after the RSTALL stall, returns the new data. No forwarding path is needed.
- `hready`=0 from another slave while this block is in IDLE: no capture, state unchanged.

## Structure
- Shared header/package `ahb_defs`: HTRANS and HSIZE encodings, HRESP_OKAY/HRESP_ERROR, and the FSM state constants. `spi_loader` and the future core bus interface reuse these.
- One sub-module, `sram_sp`: single-port synchronous RAM with 4-bit byte-enable, ADDR_WIDTH-bit word address, and 1-cycle read latency. It is kept separate so a foundry macro can replace it.
- Bus FSM, lane-strobe decode and error check live in `ahb_sram_slave`.

## Test plan
- Word write 0xDEADBEEF to 0x10, then word read 0x10 → write completes with zero waits; read has one RSTALL cycle (`hreadyout`=0), then `hrdata`=0xDEADBEEF, `hresp`=0.
- Byte writes 0x11, 0x22, 0x33, 0x44 to 0x20–0x23 (back-to-back), then two back-to-back word reads of 0x20 → `hrdata`=0x44332211 both times, the second read with zero waits.
- Halfword write 0xABCD to 0x32 over a word previously written as 0x00000000 → read 0x30 returns 0xABCD0000.
- Word write to 0x41 → ERR1 (`hreadyout`=0, `hresp`=1), then ERR2 (`hreadyout`=1, `hresp`=1); a read of 0x40 afterwards shows unchanged data.
- 16-beat INCR write burst from `spi_loader` (`hburst`=1) to 0x0–0x3C, then read back → all 16 words match, no wait states during the burst.
- Assert `reset`=0 during a WRITE data phase → `hreadyout`=1, `hresp`=0, `hrdata`=0 immediately; the target word keeps its old value.
